axi_lite_arbiter: RTL
=====================

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, giving the AXI4-Lite address width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have master-side write-address ports M_AWVALID in [1:0], M_AWREADY out [1:0] and M_AWADDR in [2*ADDR_WIDTH-1:0], with master i on slice i.
REQ-005 SHALL have master-side write-data ports M_WVALID in [1:0], M_WREADY out [1:0], M_WDATA in [63:0] and M_WSTRB in [7:0].
REQ-006 SHALL have master-side write-response ports M_BVALID out [1:0], M_BREADY in [1:0] and M_BRESP out [3:0].
REQ-007 SHALL have master-side read ports M_ARVALID in [1:0], M_ARREADY out [1:0], M_ARADDR in [2*ADDR_WIDTH-1:0], M_RVALID out [1:0], M_RREADY in [1:0], M_RDATA out [63:0] and M_RRESP out [3:0].
REQ-008 SHALL have slave-side ports S_AW*/S_W*/S_B*/S_AR*/S_R*: single-width, mirrored directions, S_AWPROT and S_ARPROT out [2:0] driven 3'b000.
REQ-009 SHALL have outputs grant [1:0] (one-hot owner, 0 when idle) and busy [0:0].

Function
REQ-010 SHALL run FSM states IDLE, RADDR, RDATA, WADDR, WRESP; exactly one transaction outstanding.
REQ-011 SHALL treat master i as requesting when M_ARVALID[i] or (M_AWVALID[i] and M_WVALID[i]).
REQ-012 SHALL, in IDLE with any request, register grant and move to WADDR if the winner has a write request, else RADDR; write wins over read within one master.
REQ-013 SHALL assert S_* VALID no earlier than the cycle after the grant is registered; the IDLE-to-slave latency is 1 cycle.
REQ-014 SHALL in RADDR route the winner's AR to S_AR; on S_ARVALID&&S_ARREADY go to RDATA.
REQ-015 SHALL in RDATA route S_R to the winner; on S_RVALID&&M_RREADY[winner] go to IDLE and clear grant.
REQ-016 SHALL in WADDR pass AW and W independently, recording each handshake; when both are done, in any order or the same cycle, go to WRESP.
REQ-017 SHALL in WRESP route S_B to the winner; on S_BVALID&&M_BREADY[winner] go to IDLE.
REQ-018 SHALL hold all READY/VALID outputs toward the non-granted master at 0, and its data outputs at 0.
REQ-019 SHALL never drop a VALID toward the slave before its handshake completes.
REQ-020 SHALL assert busy whenever the state is not IDLE.

Reset
REQ-021 SHALL on rst force state IDLE, grant 2'b00, busy 0, AW/W-done flags 0, the round-robin pointer to master 0, and all VALID/READY outputs 0, immediately and mid-transaction.
REQ-022 SHALL start arbitration on the first rising clk after rst deasserts.

Configuration
REQ-023 SHALL with macro AXI_ARB_RR_EN defined use round-robin: on a simultaneous request, the master not served last wins; the pointer updates on return to IDLE.
REQ-024 SHALL without AXI_ARB_RR_EN use fixed priority, where master 0 always wins a simultaneous request.

Verification
REQ-025 Single read: M_ARVALID=2'b01, addr 0x100; slave returns 0xDEADBEEF -> M_RDATA[31:0]=0xDEADBEEF, grant=01, then IDLE.
REQ-026 Simultaneous reads from both masters, twice, with RR -> grants 01,10,01,10; without RR -> grants 01,01,...
REQ-027 Write with S_WREADY 3 cycles after S_AWREADY -> single S_B routed to master 1, M_BRESP[3:2]=2'b00.
REQ-028 Master 0 has AR and AW+W together -> write is served first, then read.
REQ-029 rst asserted in RDATA -> grant=00, S_RREADY=0, busy=0 in the same cycle; the next request is accepted normally.
REQ-030 Slave BVALID held while M_BREADY=0 for 5 cycles -> FSM stays in WRESP, master 0 outputs stay 0.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// Two AXI4-Lite masters sharing one slave, with exactly one transaction in flight; slave VALIDs follow the grant by one cycle.
// Defining AXI_ARB_RR_EN selects round-robin tie-breaking; otherwise master 0 has fixed priority.
module axi_lite_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              M_AWVALID,
  output logic [1:0]              M_AWREADY,
  input  logic [2*ADDR_WIDTH-1:0] M_AWADDR,
  input  logic [1:0]              M_WVALID,
  output logic [1:0]              M_WREADY,
  input  logic [63:0]             M_WDATA,
  input  logic [7:0]              M_WSTRB,
  output logic [1:0]              M_BVALID,
  input  logic [1:0]              M_BREADY,
  output logic [3:0]              M_BRESP,
  input  logic [1:0]              M_ARVALID,
  output logic [1:0]              M_ARREADY,
  input  logic [2*ADDR_WIDTH-1:0] M_ARADDR,
  output logic [1:0]              M_RVALID,
  input  logic [1:0]              M_RREADY,
  output logic [63:0]             M_RDATA,
  output logic [3:0]              M_RRESP,
  output logic                    S_AWVALID,
  input  logic                    S_AWREADY,
  output logic [ADDR_WIDTH-1:0]   S_AWADDR,
  output logic [2:0]              S_AWPROT,
  output logic                    S_WVALID,
  input  logic                    S_WREADY,
  output logic [31:0]             S_WDATA,
  output logic [3:0]              S_WSTRB,
  input  logic                    S_BVALID,
  output logic                    S_BREADY,
  input  logic [1:0]              S_BRESP,
  output logic                    S_ARVALID,
  input  logic                    S_ARREADY,
  output logic [ADDR_WIDTH-1:0]   S_ARADDR,
  output logic [2:0]              S_ARPROT,
  input  logic                    S_RVALID,
  output logic                    S_RREADY,
  input  logic [31:0]             S_RDATA,
  input  logic [1:0]              S_RRESP,
  output logic [1:0]              grant,
  output logic [0:0]              busy
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic [1:0] req, wreq;
  logic       pick1;
  logic       win;
  logic       ar_hs, aw_hs, w_hs, r_hs, b_hs;

  assign wreq = M_AWVALID & M_WVALID;
  assign req  = M_ARVALID | wreq;
  assign win  = grant_q[1];

`ifdef AXI_ARB_RR_EN
  // prio_q names the master that wins a tie: the one not served last.
  logic prio_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prio_q <= 1'b0;
    else if (state_q != IDLE && state_d == IDLE)
      prio_q <= ~win;
  end
  assign pick1 = req[1] & (~req[0] | prio_q);
`else
  assign pick1 = req[1] & ~req[0];
`endif

  assign ar_hs = S_ARVALID & S_ARREADY;
  assign aw_hs = S_AWVALID & S_AWREADY;
  assign w_hs  = S_WVALID & S_WREADY;
  assign r_hs  = S_RVALID & S_RREADY;
  assign b_hs  = S_BVALID & S_BREADY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d   = pick1 ? 2'b10 : 2'b01;
          state_d   = wreq[pick1] ? WADDR : RADDR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      RADDR: if (ar_hs) state_d = RDATA;
      RDATA: begin
        if (r_hs) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      WADDR: begin
        // AW and W complete independently; either order or both at once.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (b_hs) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Slave VALIDs depend only on state, so they cannot drop before their handshake.
  assign S_ARVALID = (state_q == RADDR);
  assign S_AWVALID = (state_q == WADDR) & ~aw_done_q;
  assign S_WVALID  = (state_q == WADDR) & ~w_done_q;
  assign S_RREADY  = (state_q == RDATA) & M_RREADY[win];
  assign S_BREADY  = (state_q == WRESP) & M_BREADY[win];
  assign S_ARADDR  = win ? M_ARADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : M_ARADDR[ADDR_WIDTH-1:0];
  assign S_AWADDR  = win ? M_AWADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : M_AWADDR[ADDR_WIDTH-1:0];
  assign S_WDATA   = win ? M_WDATA[63:32] : M_WDATA[31:0];
  assign S_WSTRB   = win ? M_WSTRB[7:4] : M_WSTRB[3:0];
  assign S_AWPROT  = 3'b000;
  assign S_ARPROT  = 3'b000;

  always_comb begin
    M_ARREADY = 2'b00;
    M_AWREADY = 2'b00;
    M_WREADY  = 2'b00;
    M_RVALID  = 2'b00;
    M_BVALID  = 2'b00;
    M_RDATA   = 64'd0;
    M_RRESP   = 4'd0;
    M_BRESP   = 4'd0;
    case (state_q)
      RADDR: M_ARREADY[win] = S_ARREADY;
      RDATA: begin
        M_RVALID[win] = S_RVALID;
        M_RDATA       = win ? {S_RDATA, 32'd0} : {32'd0, S_RDATA};
        M_RRESP       = win ? {S_RRESP, 2'd0} : {2'd0, S_RRESP};
      end
      WADDR: begin
        M_AWREADY[win] = S_AWREADY & ~aw_done_q;
        M_WREADY[win]  = S_WREADY & ~w_done_q;
      end
      WRESP: begin
        M_BVALID[win] = S_BVALID;
        M_BRESP       = win ? {S_BRESP, 2'd0} : {2'd0, S_BRESP};
      end
      default: ;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule
